// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Contents: opcode constants, datapath strobe bit positions inside the
// enable/busSelect vectors, ALU operation codes, the sequencer state
// encoding and the instruction class produced by the opcode decoder.
package cpu_ctrl_pkg;

  // Opcodes (ir[31:27])
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;

  // enable[] bit positions
  localparam int EN_MARIN = 25;
  localparam int EN_IRIN  = 24;
  localparam int EN_MDRIN = 21;
  localparam int EN_PCIN  = 20;
  localparam int EN_YIN   = 19;
  localparam int EN_ZIN   = 18;

  // busSelect[] bit positions
  localparam int BS_COUT    = 23;
  localparam int BS_MDROUT  = 21;
  localparam int BS_PCOUT   = 20;
  localparam int BS_ZLOWOUT = 19;

  // ALU operation codes
  localparam logic [4:0] ALU_IDLE  = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_AND   = 5'd3;
  localparam logic [4:0] ALU_OR    = 5'd4;
  localparam logic [4:0] ALU_INCPC = 5'd14;

  localparam int CU_STATE_W = 4;

  typedef enum logic [CU_STATE_W-1:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU_R, C_ALU_I, C_LDI, C_LD, C_ST, C_NOP, C_HALT
  } op_class_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder.
// Ports:
//   opcode   in  5  ir[31:27]
//   op_class out    instruction class (undefined opcodes fold into C_NOP)
//   alu_op   out 5  ALU operation used in the execute phase
module control_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic [4:0] alu_op
);

  always_comb begin
    op_class = C_NOP;
    alu_op   = ALU_IDLE;
    case (opcode)
      OP_ADD:  begin op_class = C_ALU_R; alu_op = ALU_ADD; end
      OP_SUB:  begin op_class = C_ALU_R; alu_op = ALU_SUB; end
      OP_AND:  begin op_class = C_ALU_R; alu_op = ALU_AND; end
      OP_OR:   begin op_class = C_ALU_R; alu_op = ALU_OR;  end
      OP_ADDI: begin op_class = C_ALU_I; alu_op = ALU_ADD; end
      OP_ANDI: begin op_class = C_ALU_I; alu_op = ALU_AND; end
      OP_ORI:  begin op_class = C_ALU_I; alu_op = ALU_OR;  end
      // Loads and stores form their effective address with an add
      OP_LDI:  begin op_class = C_LDI;   alu_op = ALU_ADD; end
      OP_LD:   begin op_class = C_LD;    alu_op = ALU_ADD; end
      OP_ST:   begin op_class = C_ST;    alu_op = ALU_ADD; end
      OP_HALT: op_class = C_HALT;
      default: op_class = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer driving every datapath strobe.
// Ports:
//   clk, clr (async active-low reset), ir (instruction register),
//   stop (halt request sampled at instruction boundaries),
//   enable / busSelect (register load enables / one-hot bus source),
//   Gra/Grb/Grc, Rin/Rout/BAout, MD_Read, ReadRAM/WriteRAM,
//   Control_Signals (ALU op), run (high while sequencing).
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int ALU_W   = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       ir,
  input  logic              stop,
  output logic [31:0]       enable,
  output logic [31:0]       busSelect,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              Rin,
  output logic              Rout,
  output logic              BAout,
  output logic              MD_Read,
  output logic              ReadRAM,
  output logic              WriteRAM,
  output logic [ALU_W-1:0]  Control_Signals,
  output logic              run
);

  logic [STATE_W-1:0] state_q;
  state_t             cur, nxt, boundary;
  op_class_t          dec_cls, cls_q;
  logic [4:0]         dec_alu, alu_q;
  logic               unused_ir;

  assign unused_ir = ^ir[26:0];
  assign cur       = state_t'(state_q);

  control_decode u_decode (
    .opcode   (ir[31:27]),
    .op_class (dec_cls),
    .alu_op   (dec_alu)
  );

  // The decoded class is captured when leaving T2 so the execute phase
  // does not depend on ir staying stable afterwards.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= STATE_W'(S_RESET);
      cls_q   <= C_NOP;
      alu_q   <= ALU_IDLE;
    end else begin
      state_q <= STATE_W'(nxt);
      if (cur == S_T2) begin
        cls_q <= dec_cls;
        alu_q <= dec_alu;
      end
    end
  end

  always_comb begin
    boundary = stop ? S_HALT : S_T0;
    nxt      = cur;
    case (cur)
      S_RESET: nxt = S_T0;
      S_T0:    nxt = S_T1;
      S_T1:    nxt = S_T2;
      S_T2: begin
        case (dec_cls)
          C_NOP:   nxt = S_T0;
          C_HALT:  nxt = S_HALT;
          default: nxt = S_T3;
        endcase
      end
      S_T3:    nxt = S_T4;
      S_T4:    nxt = S_T5;
      S_T5:    nxt = (cls_q == C_LD || cls_q == C_ST) ? S_T6 : boundary;
      S_T6:    nxt = S_T7;
      S_T7:    nxt = boundary;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_RESET;
    endcase
  end

  always_comb begin
    enable          = '0;
    busSelect       = '0;
    Gra             = 1'b0;
    Grb             = 1'b0;
    Grc             = 1'b0;
    Rin             = 1'b0;
    Rout            = 1'b0;
    BAout           = 1'b0;
    MD_Read         = 1'b0;
    ReadRAM         = 1'b0;
    WriteRAM        = 1'b0;
    Control_Signals = '0;
    run             = (cur != S_RESET) && (cur != S_HALT);
    case (cur)
      S_T0: begin
        busSelect[BS_PCOUT] = 1'b1;
        enable[EN_MARIN]    = 1'b1;
        enable[EN_ZIN]      = 1'b1;
        Control_Signals     = ALU_W'(ALU_INCPC);
      end
      S_T1: begin
        busSelect[BS_ZLOWOUT] = 1'b1;
        enable[EN_PCIN]       = 1'b1;
        enable[EN_MDRIN]      = 1'b1;
        MD_Read               = 1'b1;
        ReadRAM               = 1'b1;
      end
      S_T2: begin
        busSelect[BS_MDROUT] = 1'b1;
        enable[EN_IRIN]      = 1'b1;
      end
      S_T3: begin
        // Register operand for ALU forms, base address for memory forms
        Grb            = 1'b1;
        enable[EN_YIN] = 1'b1;
        if (cls_q == C_ALU_R || cls_q == C_ALU_I) Rout  = 1'b1;
        else                                      BAout = 1'b1;
      end
      S_T4: begin
        enable[EN_ZIN]  = 1'b1;
        Control_Signals = ALU_W'(alu_q);
        if (cls_q == C_ALU_R) begin
          Grc  = 1'b1;
          Rout = 1'b1;
        end else begin
          busSelect[BS_COUT] = 1'b1;
        end
      end
      S_T5: begin
        busSelect[BS_ZLOWOUT] = 1'b1;
        if (cls_q == C_LD || cls_q == C_ST) begin
          enable[EN_MARIN] = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      S_T6: begin
        enable[EN_MDRIN] = 1'b1;
        if (cls_q == C_LD) begin
          MD_Read = 1'b1;
          ReadRAM = 1'b1;
        end else begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end
      end
      S_T7: begin
        if (cls_q == C_LD) begin
          busSelect[BS_MDROUT] = 1'b1;
          Gra                  = 1'b1;
          Rin                  = 1'b1;
        end else begin
          WriteRAM = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr, stop;
  logic [31:0] ir;
  logic [31:0] enable, busSelect;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, MD_Read, ReadRAM, WriteRAM, run;
  logic [4:0]  Control_Signals;

  control_unit #(.STATE_W(4), .ALU_W(5)) dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop),
    .enable(enable), .busSelect(busSelect),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .MD_Read(MD_Read), .ReadRAM(ReadRAM), .WriteRAM(WriteRAM),
    .Control_Signals(Control_Signals), .run(run)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] en;
    logic [31:0] bs;
    logic gra, grb, grc, rin, rout, baout, mdrd, rdram, wrram;
    logic [4:0] ctl;
    logic run;
  } ovec_t;

  typedef struct {
    ovec_t v;
    string tag;
  } exp_t;

  exp_t  q[$];
  int    total = 0;
  int    bad   = 0;
  ovec_t act;

  assign act = {enable, busSelect, Gra, Grb, Grc, Rin, Rout, BAout,
                MD_Read, ReadRAM, WriteRAM, Control_Signals, run};

  // Reference model: instruction length and per-step micro-operations.
  function automatic int instr_len(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b01100, 5'b01101, 5'b01110, 5'b00001: return 6;
      5'b00000, 5'b00010:                     return 8;
      default:                                return 3;
    endcase
  endfunction

  function automatic ovec_t step_vec(input logic [4:0] op, input int s);
    ovec_t v;
    bit    r, i, ld, st;
    logic [4:0] aop;
    v     = '0;
    v.run = 1'b1;
    r  = (op == 5'd3) || (op == 5'd4) || (op == 5'd5) || (op == 5'd6);
    i  = (op == 5'd12) || (op == 5'd13) || (op == 5'd14);
    ld = (op == 5'd0);
    st = (op == 5'd2);
    case (op)
      5'd4:         aop = 5'd2;
      5'd5, 5'd13:  aop = 5'd3;
      5'd6, 5'd14:  aop = 5'd4;
      default:      aop = 5'd1;
    endcase
    case (s)
      0: begin v.bs[20] = 1; v.en[25] = 1; v.en[18] = 1; v.ctl = 5'd14; end
      1: begin v.bs[19] = 1; v.en[20] = 1; v.en[21] = 1; v.mdrd = 1; v.rdram = 1; end
      2: begin v.bs[21] = 1; v.en[24] = 1; end
      3: begin
        v.grb = 1; v.en[19] = 1;
        if (r || i) v.rout = 1; else v.baout = 1;
      end
      4: begin
        v.en[18] = 1; v.ctl = aop;
        if (r) begin v.grc = 1; v.rout = 1; end else v.bs[23] = 1;
      end
      5: begin
        v.bs[19] = 1;
        if (ld || st) v.en[25] = 1; else begin v.gra = 1; v.rin = 1; end
      end
      6: begin
        v.en[21] = 1;
        if (ld) begin v.mdrd = 1; v.rdram = 1; end else begin v.gra = 1; v.rout = 1; end
      end
      default: begin
        if (ld) begin v.bs[21] = 1; v.gra = 1; v.rin = 1; end else v.wrram = 1;
      end
    endcase
    return v;
  endfunction

  task automatic check_vec(input string tag, input ovec_t got, input ovec_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic push_exp(input ovec_t v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: one output vector per cycle, plus structural invariants.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check_vec(e.tag, act, e.v);
    end
    total++;
    if (!$onehot0(busSelect)) begin
      bad++;
      $display("FAIL bus_onehot got=%h want=at most one bit", busSelect);
    end
    total++;
    if (Grb && Rout && BAout) begin
      bad++;
      $display("FAIL grb_excl got=Rout&BAout want=not both");
    end
  end

  // Pulls clr low after the current cycle is sampled, checks the clear is
  // immediate, holds two cycles, releases; returns #1 after entering T0.
  task automatic reset_seq();
    @(negedge clk);
    #1 clr = 1'b0;
    #1 check_vec("async_clr", act, '0);
    push_exp('0, "clr_low");
    push_exp('0, "clr_low");
    @(negedge clk);
    @(negedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after entering T0. abort_at>0 pulls clr during that step.
  task automatic run_instr(input logic [31:0] instr, input bit stop_end,
                           input bit stop_mid, input int abort_at);
    logic [4:0] op;
    int         len;
    int         upto;
    bit         halts;
    op    = instr[31:27];
    len   = instr_len(op);
    ir    = instr;
    halts = (op == 5'b11001) || (stop_end && len > 3);
    upto  = (abort_at > 0) ? abort_at + 1 : len;
    for (int s = 0; s < upto; s++) push_exp(step_vec(op, s), $sformatf("op%b_T%0d", op, s));
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      reset_seq();
      return;
    end
    if (halts) for (int h = 0; h < 3; h++) push_exp('0, $sformatf("op%b_halt%0d", op, h));
    for (int c = 1; c <= len; c++) begin
      @(posedge clk);
      #1 stop = (stop_end && len > 3 && c == len - 1) || (stop_mid && len > 4 && c == 3);
    end
    stop = 1'b0;
    if (halts) begin
      repeat (2) @(posedge clk);
      reset_seq();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] rop;
    clr  = 1'b0;
    stop = 1'b0;
    ir   = 32'h0;
    push_exp('0, "reset");
    push_exp('0, "reset");
    @(negedge clk);
    @(negedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1;

    run_instr(32'h71180008, 0, 0, 0);                 // ori
    run_instr({5'b00000, 27'h0123456}, 0, 0, 0);      // ld
    run_instr({5'b00010, 27'h0654321}, 0, 0, 0);      // st
    run_instr({5'b00011, 27'h0111111}, 0, 0, 0);      // add
    run_instr({5'b00100, 27'h0222222}, 0, 0, 0);      // sub
    run_instr({5'b00101, 27'h0333333}, 0, 0, 0);      // and
    run_instr({5'b00110, 27'h0444444}, 0, 0, 0);      // or
    run_instr({5'b01100, 27'h0555555}, 0, 0, 0);      // addi
    run_instr({5'b01101, 27'h0666666}, 0, 0, 0);      // andi
    run_instr({5'b00001, 27'h0777777}, 0, 0, 0);      // ldi
    run_instr({5'b11000, 27'h0}, 0, 0, 0);            // nop
    run_instr({5'b10111, 27'h7ffffff}, 0, 0, 0);      // undefined
    run_instr({5'b00011, 27'h0123123}, 0, 0, 4);      // clr during T4
    run_instr({5'b01100, 27'h0a0a0a0}, 1, 0, 0);      // stop at boundary
    run_instr({5'b01100, 27'h0b0b0b0}, 0, 1, 0);      // stop mid-instruction
    run_instr({5'b00000, 27'h0c0c0c0}, 1, 0, 0);      // stop after ld
    run_instr({5'b11001, 27'h0}, 0, 0, 0);            // halt

    for (int n = 0; n < 40; n++) begin
      rop = 5'($urandom_range(0, 31));
      run_instr({rop, 27'($urandom)}, ($urandom % 8) == 0, ($urandom % 4) == 0, 0);
    end

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
